// File: rtl/stack_seq.sv
// stack_seq: hardware stack sequencer for PUSH/POP/CALL/RET/INT/RTI.
// Each accepted request becomes a short burst of 16-bit word writes or reads
// on the data-memory port.
// SP is post-decrement on push and pre-increment on pop.
// Build option: define STACK_CHECK_EN to enable overflow/underflow guarding.
// With it defined, a guarded access is suppressed and the sticky stack_err is set.
// Without it, SP wraps freely and stack_err is tied low.
module stack_seq #(
  parameter int unsigned       ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [15:0]       wdata,
  input  logic [31:0]       pc_in,
  input  logic [2:0]        flags_in,
  input  logic [15:0]       mem_rdata,
  output logic              ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              pop_valid,
  output logic [15:0]       pop_data,
  output logic              pc_load,
  output logic [31:0]       pc_out,
  output logic              flags_load,
  output logic [2:0]        flags_out,
  output logic              done,
  output logic              stack_err,
  output logic [ADDR_W-1:0] sp_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PUSH   = 2'd1,
    S_POP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_INT  = 3'b100;
  localparam logic [2:0] OP_RTI  = 3'b101;

  localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [1:0]          r_cnt;       // words still to transfer in this sequence
  logic [ADDR_W-1:0]   r_sp;
  logic [2:0]          r_op;
  logic [15:0]         r_wdata;
  logic [31:0]         r_pc;
  logic [2:0]          r_flags;
  logic [15:0]         r_lo;        // popped PC low half (RET/RTI)
  logic [2:0]          r_fw;        // popped flags word (RTI)

  state_t              w_state_next;
  logic [1:0]          w_cnt_next;
  logic [ADDR_W-1:0]   w_sp_next;
  logic                w_accept;
  logic [15:0]         w_push_word;
  logic                w_push_blk;
  logic                w_pop_blk;

`ifdef STACK_CHECK_EN
  logic r_stack_err;
  logic w_err_set;

  // A push into address 0 or a pop from an empty stack is refused.
  assign w_push_blk = (r_sp == '0);
  assign w_pop_blk  = (r_sp == SP_INIT);
  assign w_err_set  = ((r_state == S_PUSH) && w_push_blk) ||
                      ((r_state == S_POP)  && w_pop_blk);
  assign stack_err  = r_stack_err;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stack_err <= 1'b0;
    end else if (w_err_set) begin
      r_stack_err <= 1'b1;
    end
  end
`else
  assign w_push_blk = 1'b0;
  assign w_pop_blk  = 1'b0;
  assign stack_err  = 1'b0;
`endif

  assign sp_out = r_sp;

  // Select the word to write; r_cnt counts down, so the highest count goes first.
  always_comb begin
    w_push_word = r_wdata;
    case (r_op)
      OP_CALL: w_push_word = (r_cnt == 2'd2) ? r_pc[31:16] : r_pc[15:0];
      OP_INT: begin
        case (r_cnt)
          2'd3:    w_push_word = r_pc[31:16];
          2'd2:    w_push_word = r_pc[15:0];
          default: w_push_word = {13'b0, r_flags};
        endcase
      end
      default: w_push_word = r_wdata;
    endcase
  end

  // Next-state, SP update and all port outputs.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sp_next    = r_sp;
    w_accept     = 1'b0;
    ready        = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    pop_valid    = 1'b0;
    pop_data     = '0;
    pc_load      = 1'b0;
    pc_out       = '0;
    flags_load   = 1'b0;
    flags_out    = '0;
    done         = 1'b0;

    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        // 11x op_codes are reserved and silently dropped.
        if (op_valid && (op_code[2:1] != 2'b11)) begin
          w_accept = 1'b1;
          case (op_code)
            OP_PUSH: begin w_state_next = S_PUSH; w_cnt_next = 2'd1; end
            OP_CALL: begin w_state_next = S_PUSH; w_cnt_next = 2'd2; end
            OP_INT:  begin w_state_next = S_PUSH; w_cnt_next = 2'd3; end
            OP_POP:  begin w_state_next = S_POP;  w_cnt_next = 2'd1; end
            OP_RET:  begin w_state_next = S_POP;  w_cnt_next = 2'd2; end
            default: begin w_state_next = S_POP;  w_cnt_next = 2'd3; end
          endcase
        end
      end

      S_PUSH: begin
        if (w_push_blk) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
          w_cnt_next   = 2'd0;
        end else begin
          mem_we    = 1'b1;
          mem_addr  = r_sp;
          mem_wdata = w_push_word;
          w_sp_next = r_sp - SP_ONE;
          if (r_cnt == 2'd1) begin
            // Pushes finish on the last write; no FINISH cycle is needed.
            done         = 1'b1;
            w_state_next = S_IDLE;
            w_cnt_next   = 2'd0;
          end else begin
            w_cnt_next = r_cnt - 2'd1;
          end
        end
      end

      S_POP: begin
        if (w_pop_blk) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
          w_cnt_next   = 2'd0;
        end else begin
          mem_re    = 1'b1;
          mem_addr  = r_sp + SP_ONE;
          w_sp_next = r_sp + SP_ONE;
          if (r_cnt == 2'd1) begin
            w_state_next = S_FINISH;
            w_cnt_next   = 2'd0;
          end else begin
            w_cnt_next = r_cnt - 2'd1;
          end
        end
      end

      S_FINISH: begin
        // The final read's data arrives this cycle and is used directly.
        done         = 1'b1;
        w_state_next = S_IDLE;
        case (r_op)
          OP_POP: begin
            pop_valid = 1'b1;
            pop_data  = mem_rdata;
          end
          OP_RET: begin
            pc_load = 1'b1;
            pc_out  = {mem_rdata, r_lo};
          end
          OP_RTI: begin
            pc_load    = 1'b1;
            pc_out     = {mem_rdata, r_lo};
            flags_load = 1'b1;
            flags_out  = r_fw;
          end
          default: ;
        endcase
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // Control state and stack pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_sp    <= SP_INIT;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sp    <= w_sp_next;
    end
  end

  // Latch the request operands when a request is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= 3'd0;
      r_wdata <= 16'd0;
      r_pc    <= 32'd0;
      r_flags <= 3'd0;
    end else if (w_accept) begin
      r_op    <= op_code;
      r_wdata <= wdata;
      r_pc    <= pc_in;
      r_flags <= flags_in;
    end
  end

  // Capture the data of the previous read.
  // The word read at count k returns while r_cnt == k-1: count 3 is flags, count 2 is the PC low half.
  // Captures during a sequence's first read are stale but never consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo <= 16'd0;
      r_fw <= 3'd0;
    end else if (r_state == S_POP) begin
      if (r_cnt == 2'd2) begin
        r_fw <= mem_rdata[2:0];
      end
      if (r_cnt == 2'd1) begin
        r_lo <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, data-memory word-address width.
REQ-002 SHALL have parameter SP_INIT, default {ADDR_W{1'b1}}, empty-stack SP value.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port op_valid  input  1  stack operation request.
REQ-006 SHALL have port op_code  input  3  000 PUSH, 001 POP, 010 CALL, 011 RET, 100 INT, 101 RTI, 11x reserved.
REQ-007 SHALL have port wdata  input  16  PUSH payload.
REQ-008 SHALL have port pc_in  input  32  return PC for CALL/INT.
REQ-009 SHALL have port flags_in  input  3  {C,N,Z} for INT.
REQ-010 SHALL have port mem_rdata  input  16  data memory read data, valid 1 cycle after mem_re.
REQ-011 SHALL have port ready  output  1  high only in IDLE; low stalls fetch/decode.
REQ-012 SHALL have ports mem_we/mem_re  output  1 each, mem_addr  output  ADDR_W, mem_wdata  output  16.
REQ-013 SHALL have ports pop_valid  output  1, pop_data  output  16  POP result.
REQ-014 SHALL have ports pc_load  output  1, pc_out  output  32  RET/RTI target.
REQ-015 SHALL have ports flags_load  output  1, flags_out  output  3  RTI flags.
REQ-016 SHALL have ports done  output  1 (sequence-complete pulse), stack_err  output  1 (sticky), sp_out  output  ADDR_W.

Function
REQ-017 SHALL accept a request only when op_valid && ready at cycle T, capturing op_code, wdata, pc_in, flags_in.
REQ-018 SHALL ignore reserved op_codes: stay IDLE, no memory access, no done.
REQ-019 SHALL implement states IDLE, PUSH, POP, FINISH with a 2-bit remaining-word counter.
REQ-020 Word sequences: PUSH {wdata}; CALL {pc[31:16], pc[15:0]}; INT {pc[31:16], pc[15:0], {13'b0,flags}}; POP 1 word; RET {lo, hi}; RTI {flags, lo, hi}.
REQ-021 Push word: mem_we=1, mem_addr=SP, mem_wdata=word, SP<=SP-1 (post-decrement).
REQ-022 Pop word: mem_re=1, mem_addr=SP+1, SP<=SP+1 (pre-increment).
REQ-023 Push of n words SHALL write in cycles T+1..T+n, pulse done at T+n, return to IDLE at T+n+1.
REQ-024 Pop of n words SHALL read in T+1..T+n, capture mem_rdata in T+2..T+n+1, be in FINISH at T+n+1, IDLE at T+n+2.
REQ-025 In FINISH, for exactly one cycle: done=1; POP: pop_valid=1, pop_data=word; RET: pc_load=1, pc_out={hi,lo}; RTI: additionally flags_load=1, flags_out=flags word[2:0].
REQ-026 At most one of mem_we, mem_re SHALL be high in any cycle; both low in IDLE and FINISH.
REQ-027 op_valid while ready=0 SHALL be ignored; requester holds it.
REQ-028 sp_out SHALL always equal current SP.

Reset
REQ-029 reset low SHALL immediately force IDLE, SP=SP_INIT, counter=0, all outputs 0 except ready=1 and sp_out=SP_INIT.
REQ-030 reset mid-sequence SHALL discard the partial sequence; no done, pc_load or flags_load is issued.

Configuration
REQ-031 With STACK_CHECK_EN defined: a push word with SP==0 or pop word with SP==SP_INIT SHALL be suppressed (no mem_we/mem_re, SP unchanged), set stack_err, pulse done that cycle with no pc_load/flags_load/pop_valid, and return to IDLE next cycle.
REQ-032 Without STACK_CHECK_EN: SP SHALL wrap modulo 2^ADDR_W and stack_err SHALL be tied 0.
REQ-033 stack_err SHALL clear only on reset.

Verification
REQ-034 Reset, then CALL pc_in=0x0001_0234 -> writes 0x0001@0xFFF, 0x0234@0xFFE; done at T+2; sp_out=0xFFD.
REQ-035 After REQ-034, RET -> reads 0xFFE, 0xFFF; at T+3 pc_load=1, pc_out=0x0001_0234; sp_out=0xFFF; ready at T+4.
REQ-036 INT pc_in=0x0000_0050, flags_in=3'b101 then RTI -> 3 writes then 3 reads; flags_out=3'b101, pc_out=0x0000_0050, SP back to 0xFFF.
REQ-037 PUSH 0xBEEF, POP -> pop_valid at T+2 with pop_data=0xBEEF.
REQ-038 STACK_CHECK_EN, POP on empty stack -> no mem_re, done at T+1, stack_err=1; without macro -> reads 0x000, sp_out=0x000.
REQ-039 Reset asserted at T+2 of INT -> next cycle ready=1, sp_out=0xFFF, no done observed.
